// File: rtl/csr_dispatch.sv
// CSR dispatch front end: accepts one decoded Zicsr op, resolves its operand,
// issues it to the CSR unit and waits for write-back. rst_n is active-HIGH.
module csr_dispatch #(
    parameter int XLEN       = 32,
    parameter int WB_TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush_i,
    input  logic            dec_valid_i,
    output logic            dec_ready_o,
    input  logic [2:0]      dec_funct3_i,
    input  logic [4:0]      dec_rs1_i,
    input  logic [4:0]      dec_rd_i,
    input  logic [11:0]     dec_csr_adr_i,
    output logic [4:0]      rf_rs1_adr_o,
    input  logic [XLEN-1:0] rf_rs1_data_i,
    input  logic            rf_rs1_busy_i,
    output logic [1:0]      unit_o,
    output logic [3:0]      sel_o,
    output logic            imm_o,
    output logic [XLEN-1:0] rs1_o,
    output logic [11:0]     csr_adr_o,
    output logic [4:0]      rd_o,
    input  logic            csr_ok_i,
    input  logic            wb_valid_i,
    input  logic            wb_exc_i,
    output logic            sb_set_o,
    output logic [4:0]      sb_rd_o,
    output logic            exc_o,
    output logic            err_o,
    output logic            busy_o
);

    typedef enum logic [1:0] {S_IDLE, S_OPERAND, S_ISSUE, S_WAIT_WB} state_t;

    localparam logic [7:0] LP_TIMEOUT = 8'(WB_TIMEOUT);

    state_t          r_state;
    state_t          w_next;
    logic [2:0]      r_funct3;
    logic [4:0]      r_rs1;
    logic [4:0]      r_rd;
    logic [11:0]     r_adr;
    logic [XLEN-1:0] r_operand;
    logic [7:0]      r_cnt;
    logic            r_err;

    logic w_opnd_ready;
    logic w_accept;
    logic w_capture;
    logic w_issue_ok;
    logic w_timeout;

    assign w_opnd_ready = r_funct3[2] || (r_rs1 == 5'd0) || !rf_rs1_busy_i;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge values; reset is asynchronous and asserted when rst_n is high.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        w_next      = r_state;
        dec_ready_o = 1'b0;
        unit_o      = 2'h3;
        sb_set_o    = 1'b0;
        exc_o       = 1'b0;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        w_issue_ok  = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            S_IDLE: begin
                dec_ready_o = 1'b1;
                if (dec_valid_i && !flush_i) begin
                    w_accept = 1'b1;
                    w_next   = S_OPERAND;
                end
            end
            S_OPERAND: begin
                if (flush_i) begin
                    w_next = S_IDLE;
                end else if (w_opnd_ready) begin
                    w_capture = 1'b1;
                    w_next    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                unit_o = 2'h0;
                // Accept beats flush: once the CSR unit has taken it, it is committed.
                if (csr_ok_i) begin
                    w_issue_ok = 1'b1;
                    sb_set_o   = (r_rd != 5'd0);
                    w_next     = S_WAIT_WB;
                end else if (flush_i) begin
                    w_next = S_IDLE;
                end
            end
            S_WAIT_WB: begin
                if (wb_valid_i) begin
                    exc_o  = wb_exc_i;
                    w_next = S_IDLE;
                end else if (r_cnt == LP_TIMEOUT) begin
                    w_timeout = 1'b1;
                    w_next    = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_funct3  <= '0;
            r_rs1     <= '0;
            r_rd      <= '0;
            r_adr     <= '0;
            r_operand <= '0;
            r_cnt     <= '0;
            r_err     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_funct3 <= dec_funct3_i;
                r_rs1    <= dec_rs1_i;
                r_rd     <= dec_rd_i;
                r_adr    <= dec_csr_adr_i;
            end
            if (w_capture)
                r_operand <= r_funct3[2] ? {{(XLEN-5){1'b0}}, r_rs1} : rf_rs1_data_i;
            if (w_issue_ok)
                r_cnt <= '0;
            else if (r_state == S_WAIT_WB)
                r_cnt <= r_cnt + 8'd1;
            if (w_timeout)
                r_err <= 1'b1;
        end
    end

    // Set/clear with a zero rs1 field must not write the CSR.
    assign sel_o        = {r_funct3[1] && (r_rs1 == 5'd0), r_funct3};
    assign imm_o        = r_funct3[2];
    assign rs1_o        = r_operand;
    assign csr_adr_o    = r_adr;
    assign rd_o         = r_rd;
    assign sb_rd_o      = r_rd;
    assign rf_rs1_adr_o = r_rs1;
    assign err_o        = r_err;
    assign busy_o       = (r_state != S_IDLE);

endmodule

// File: doc/csr_dispatch.md
# csr_dispatch

Issue-side front end for the CSR unit: accepts decoded Zicsr instructions from decode, resolves the source operand, and serialises them so only one CSR operation is in flight. It drives the CSR unit's request interface (unit/sel/imm/rs1/csr_adr/rd) and tracks the matching write-back completion. It also reserves the destination register in the scoreboard. It sits between the decode stage and the CSR unit, beside the register file read port.

## Interface
- XLEN, 32, data width
- WB_TIMEOUT, 255, max cycles waiting for CSR write-back before error (8-bit counter)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset rst_n, asynchronous, active-high
- flush_i  in  1  pipeline flush
- dec_valid_i  in  1  decoded CSR instruction valid
- dec_ready_o  out  1  dispatcher can accept
- dec_funct3_i  in  3  Zicsr funct3
- dec_rs1_i  in  5  rs1 index or uimm
- dec_rd_i  in  5  destination index
- dec_csr_adr_i  in  12  CSR address
- rf_rs1_adr_o  out  5  register-file read index
- rf_rs1_data_i  in  XLEN  register-file read data
- rf_rs1_busy_i  in  1  scoreboard: rs1 pending write
- unit_o  out  2  unit select; 2'h0 = CSR, 2'h3 = none
- sel_o  out  4  op select, see Operation
- imm_o  out  1  immediate form
- rs1_o  out  XLEN  resolved operand
- csr_adr_o  out  12  CSR address
- rd_o  out  5  destination
- csr_ok_i  in  1  CSR unit accepted request
- wb_valid_i  in  1  CSR result retired at write-back
- wb_exc_i  in  1  CSR result flagged exception
- sb_set_o  out  1  one-cycle pulse: mark sb_rd_o busy
- sb_rd_o  out  5  register to reserve
- exc_o  out  1  one-cycle pulse: CSR exception retired
- err_o  out  1  sticky: write-back timeout
- busy_o  out  1  FSM not IDLE

## Operation
- FSM states IDLE, OPERAND, ISSUE, WAIT_WB.
- IDLE: dec_ready_o=1. If dec_valid_i is high, latch funct3/rs1/rd/adr and go to OPERAND.
- OPERAND: rf_rs1_adr_o = latched rs1.
  - Operand ready if funct3[2]=1 (immediate), or rs1=0, or !rf_rs1_busy_i.
  - If ready: capture operand (immediate = zero-extended uimm; register = rf_rs1_data_i) and go to ISSUE. Otherwise stay.
- ISSUE: unit_o=2'h0; all request outputs driven from latches.
  - If csr_ok_i: pulse sb_set_o when rd≠0, clear the timeout counter, go to WAIT_WB.
  - Otherwise hold all outputs stable.
- WAIT_WB: counter increments each cycle.
  - If wb_valid_i: pulse exc_o=wb_exc_i and go to IDLE.
  - Else if counter==WB_TIMEOUT: set err_o and go to IDLE.
- Illegal funct3 (0 or 4) is still dispatched; the CSR unit raises the fault.
- sel_o mapping:
  - [1:0]=funct3[1:0] (01 write, 10 set, 11 clear)
  - [2]=funct3[2]
  - [3]=write-suppress, set for set/clear forms when rs1 field==0
- imm_o=funct3[2]. unit_o=2'h3 in every state except ISSUE. dec_ready_o=0 outside IDLE.
- flush_i:
  - In OPERAND or ISSUE: abort to IDLE with no sb_set_o.
  - In WAIT_WB: ignored, because the operation is committed.
  - Simultaneous flush_i and csr_ok_i in ISSUE: the accept wins and the FSM goes to WAIT_WB.
  - In IDLE, flush_i blocks acceptance that cycle.
- err_o clears only on reset.

## Timing
- Reset: state IDLE, all latches 0. Outputs: dec_ready_o=1, unit_o=2'h3, sel_o=0, imm_o=0, rs1_o=0, csr_adr_o=0, rd_o=0, sb_set_o=0, exc_o=0, err_o=0, busy_o=0.
- Asynchronous reset aborts any state, including WAIT_WB, with no pulses.
- Accept at cycle N, OPERAND at N+1, ISSUE at N+2 at the earliest. sb_set_o is asserted in the cycle csr_ok_i is sampled high.
- Minimum turnaround: accept to next dec_ready_o is 3 cycles plus write-back latency.
- Operand is sampled in the OPERAND cycle that finds it ready, and is stable through ISSUE.
- Timeout fires WB_TIMEOUT+1 cycles after entering WAIT_WB.

## Test plan
- CSRRW rs1=x5 (x5=0xDEADBEEF, not busy), adr=0x340, rd=3, csr_ok_i=1 → ISSUE at N+2 with rs1_o=0xDEADBEEF, sel_o=4'b0001, unit_o=0. sb_set_o pulses with sb_rd_o=3. After wb_valid_i, dec_ready_o=1.
- CSRRSI uimm=0, adr=0x300 → rs1_o=0, imm_o=1, sel_o=4'b1110.
- CSRRC with rf_rs1_busy_i high for 4 cycles → FSM stays in OPERAND 4 cycles, then issues with the new data value.
- csr_ok_i low for 3 cycles in ISSUE → outputs held, no sb_set_o. flush_i raised in the 2nd cycle → IDLE, unit_o=2'h3.
- wb_exc_i=1 with wb_valid_i → exc_o single pulse, FSM returns to IDLE.
- wb_valid_i never arrives → err_o=1 after 256 cycles in WAIT_WB. rst_n mid-WAIT_WB → all outputs return to reset values.
